inv_key_sched: RTL and testbench

INV_KEY_SCHED -- requirements
Module: inv_key_sched

---
 rtl/inv_key_sched.sv | 163 ++++++++++++++++
 tb/tb_inv_key_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: expands a cipher key forward to round 10, then
// streams round keys 10..0 to a consumer with valid/ready handshaking.
module inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_Start,
    input  logic [127:0] i_Key,
    input  logic         i_fLastKey,
    input  logic         i_Ready,
    output logic [127:0] o_RoundKey,
    output logic [3:0]   o_Round,
    output logic         o_Valid,
    output logic         o_Busy,
    output logic         o_Done
);

    typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t       state;
    logic [127:0] key;
    logic [3:0]   cnt;
    logic         valid;
    logic         busy;
    logic         done;

    logic [31:0]  g_in;
    logic [3:0]   g_rnd;
    logic [31:0]  g_out;
    logic [127:0] fwd_key;
    logic [127:0] rev_key;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] g_word(input logic [31:0] w, input logic [3:0] r);
        logic [31:0] rot;
        rot = {w[23:0], w[31:24]};
        return {sbox(rot[31:24]) ^ rcon(r), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    // One g instance shared by both directions; reverse feeds it the recovered w3'
    always_comb begin
        g_in  = (state == REV) ? (key[31:0] ^ key[63:32]) : key[31:0];
        g_rnd = (state == REV) ? cnt : cnt + 4'd1;
        g_out = g_word(g_in, g_rnd);

        fwd_key[127:96] = key[127:96] ^ g_out;
        fwd_key[95:64]  = key[95:64]  ^ fwd_key[127:96];
        fwd_key[63:32]  = key[63:32]  ^ fwd_key[95:64];
        fwd_key[31:0]   = key[31:0]   ^ fwd_key[63:32];

        rev_key[31:0]   = key[31:0]   ^ key[63:32];
        rev_key[63:32]  = key[63:32]  ^ key[95:64];
        rev_key[95:64]  = key[95:64]  ^ key[127:96];
        rev_key[127:96] = key[127:96] ^ g_out;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state <= IDLE;
            key   <= '0;
            cnt   <= 4'd0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        key  <= i_Key;
                        busy <= 1'b1;
                        if (i_fLastKey) begin
                            cnt   <= LAST;
                            state <= REV;
                            valid <= 1'b1;
                        end else begin
                            cnt   <= 4'd0;
                            state <= FWD;
                        end
                    end
                end
                FWD: begin
                    key <= fwd_key;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST - 4'd1) begin
                        state <= REV;
                        valid <= 1'b1;
                    end
                end
                REV: begin
                    if (valid && i_Ready) begin
                        if (cnt == 4'd0) begin
                            state <= IDLE;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            key <= rev_key;
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_RoundKey = key;
    assign o_Round    = cnt;
    assign o_Valid    = valid;
    assign o_Busy     = busy;
    assign o_Done     = done;

endmodule

// File: tb/tb_inv_key_sched.sv
// Scoreboard bench for inv_key_sched using the FIPS-197 AES-128 example key schedule.
module tb_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         flk = 1'b0;
    logic         ready = 1'b1;
    logic [127:0] o_RoundKey;
    logic [3:0]   o_Round;
    logic         o_Valid;
    logic         o_Busy;
    logic         o_Done;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] rk [0:10];
    int           tests = 0;
    int           fails = 0;

    inv_key_sched #(.NR(10)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Start    (start),
        .i_Key      (key_in),
        .i_fLastKey (flk),
        .i_Ready    (ready),
        .o_RoundKey (o_RoundKey),
        .o_Round    (o_Round),
        .o_Valid    (o_Valid),
        .o_Busy     (o_Busy),
        .o_Done     (o_Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq();
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.rnd = 4'(r);
            e.key = rk[r];
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [127:0] k, input logic last);
        start  = 1'b1;
        key_in = k;
        flk    = last;
        push_seq();
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_Valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        while (!(o_Valid && o_Round == r) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_round", 128'(o_Round), 128'(r));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!o_Done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_pulse", 128'(o_Done), 128'd1);
        chk("done_valid_low", 128'(o_Valid), 128'd0);
        chk("done_busy_low", 128'(o_Busy), 128'd0);
    endtask

    // Monitor: pops an expected key on every accepted transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_Valid && ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_key: got round %0d key %h with nothing expected", o_Round, o_RoundKey);
            end else begin
                e = sb.pop_front();
                chk("mon_round", 128'(o_Round), 128'(e.rnd));
                chk("mon_key", o_RoundKey, e.key);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(o_Valid), 128'd0);
        chk("rst_busy", 128'(o_Busy), 128'd0);
        chk("rst_done", 128'(o_Done), 128'd0);
        chk("rst_round", 128'(o_Round), 128'd0);
        chk("rst_key", o_RoundKey, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 128'(o_Busy), 128'd0);

        // Forward expansion then reverse stream
        issue(rk[0], 1'b0);
        chk("fwd_busy", 128'(o_Busy), 128'd1);
        chk("fwd_valid_low", 128'(o_Valid), 128'd0);
        wait_valid(n);
        chk("fwd_latency", 128'(n + 1), 128'd11);
        chk("first_round", 128'(o_Round), 128'd10);
        chk("first_key", o_RoundKey, rk[10]);
        wait_done();
        @(posedge clk); #1;
        chk("done_one_cycle", 128'(o_Done), 128'd0);
        chk("sb_empty_a", 128'(sb.size()), 128'd0);

        // Direct reverse from the round-10 key
        issue(rk[10], 1'b1);
        wait_valid(n);
        chk("rev_latency", 128'(n + 1), 128'd1);
        wait_done();
        @(posedge clk); #1;
        chk("sb_empty_b", 128'(sb.size()), 128'd0);

        // Backpressure at round 7
        issue(rk[10], 1'b1);
        wait_round(4'd7);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_round", 128'(o_Round), 128'd7);
            chk("stall_key", o_RoundKey, rk[7]);
            chk("stall_valid", 128'(o_Valid), 128'd1);
        end
        ready = 1'b1;
        wait_done();
        @(posedge clk); #1;
        chk("sb_empty_c", 128'(sb.size()), 128'd0);

        // Start pulses during FWD and REV are ignored
        issue(rk[0], 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b1; key_in = '1; flk = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_round(4'd5);
        start = 1'b1; key_in = 128'h0123456789abcdef0123456789abcdef; flk = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("sb_empty_d", 128'(sb.size()), 128'd0);

        // Reset mid-REV abandons the sequence
        issue(rk[10], 1'b1);
        wait_round(4'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        chk("mid_rst_valid", 128'(o_Valid), 128'd0);
        chk("mid_rst_busy", 128'(o_Busy), 128'd0);
        chk("mid_rst_round", 128'(o_Round), 128'd0);
        chk("mid_rst_key", o_RoundKey, 128'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_done", 128'(o_Done), 128'd0);
            @(posedge clk); #1;
        end
        issue(rk[0], 1'b0);
        wait_valid(n);
        chk("post_rst_latency", 128'(n + 1), 128'd11);
        wait_done();
        @(posedge clk); #1;
        chk("sb_empty_e", 128'(sb.size()), 128'd0);

        // Back-to-back: new start in the done cycle
        issue(rk[10], 1'b1);
        wait_done();
        issue(rk[10], 1'b1);
        chk("b2b_valid", 128'(o_Valid), 128'd1);
        chk("b2b_round", 128'(o_Round), 128'd10);
        wait_done();
        @(posedge clk); #1;
        chk("sb_empty_f", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
